// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 divider family.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package div_pkg;

  // Operation sequencing: accept -> iterate -> sign fix -> hold result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Iteration counter width: must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate of a quotient/remainder pair (shared with the multiplier).
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic             neg_quo_i,
  input  logic             neg_rem_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  assign quo_o = neg_quo_i ? -quo_i : quo_i;
  assign rem_o = neg_rem_i ? -rem_i : rem_i;

endmodule

// File: rtl/div_radix2_param.sv
// Radix-2 restoring divider, signed/unsigned, WIDTH-generic; optional macro DIV_FAST_PATH_EN skips CALC/FIX for b==0 or |a|<|b|.
// Latency: out_valid is seen WIDTH+2 cycles counting the accept cycle (WIDTH CALC + FIX + DONE); fast path: DONE one edge after accept.
// Backpressure: one op in flight; in_ready low until out_ready takes the result, which is held stable meanwhile; flush aborts.
module div_radix2_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             b_zero_q, b_zero_d;
  // Partial remainder and dividend/quotient halves of the shift register.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  // Negated divisor magnitude, one bit wider so |MIN| and the carry both fit.
  logic [WIDTH:0]   nb_q, nb_d;
  logic [WIDTH-1:0] q_res_q, q_res_d;
  logic [WIDTH-1:0] r_res_q, r_res_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             b_zero_in;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             carry;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] fix_q, fix_r;
  logic             unused_trial_msb;

  assign a_mag     = (sign && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (sign && b[WIDTH-1]) ? -b : b;
  assign b_zero_in = (b == '0);

  // Trial subtract: carry out of rem_sh + (-|b|) means rem_sh >= |b|.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = {1'b0, rem_sh} + {1'b0, nb_q};
  assign carry  = trial[WIDTH+1];
  // After a successful subtract the result is below |b|, so this bit is always 0.
  assign unused_trial_msb = trial[WIDTH];

  // Remainder follows the dividend sign; quotient negates on sign mismatch.
  // With b==0 no subtract ever succeeds, so the restored remainder is |a| and
  // the sign fix turns it back into a unchanged.
  assign neg_q = sign_q & (a_msb_q ^ b_msb_q);
  assign neg_r = sign_q & a_msb_q;

  div_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .quo_i    (quo_q),
    .rem_i    (rem_q),
    .neg_quo_i(neg_q),
    .neg_rem_i(neg_r),
    .quo_o    (fix_q),
    .rem_o    (fix_r)
  );

  // Next-state and datapath update; flush overrides everything at the end.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    b_zero_d = b_zero_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    nb_d     = nb_q;
    q_res_d  = q_res_q;
    r_res_d  = r_res_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          sign_d   = sign;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          b_zero_d = b_zero_in;
          rem_d    = '0;
          quo_d    = a_mag;
          nb_d     = -{1'b0, b_mag};
          cnt_d    = CNT_ONE;
          state_d  = CALC;
`ifdef DIV_FAST_PATH_EN
          if (b_zero_in || (a_mag < b_mag)) begin
            q_res_d = b_zero_in ? '1 : '0;
            r_res_d = a;
            dbz_d   = b_zero_in;
            cnt_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        rem_d = carry ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], carry};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      FIX: begin
        q_res_d = b_zero_q ? '1 : fix_q;
        r_res_d = fix_r;
        dbz_d   = b_zero_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Control state: FSM, counter and operand sign/zero flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      b_zero_q <= b_zero_d;
    end
  end

  // Iteration datapath and registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      nb_q    <= '0;
      q_res_q <= '0;
      r_res_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      nb_q    <= nb_d;
      q_res_q <= q_res_d;
      r_res_q <= r_res_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_res_q;
  assign remainder   = r_res_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_radix2_param.sv
// Directed bench for div_radix2_param at WIDTH=32 and WIDTH=8.
// Latency counts cycles from the accept cycle through the first cycle out_valid is seen.
// Consumer backpressure is exercised with a held out_ready=0 window.
module tb_div_radix2_param;

`ifdef DIV_FAST_PATH_EN
  localparam int FAST32 = 1;
  localparam int FAST8  = 1;
`else
  localparam int FAST32 = 34;
  localparam int FAST8  = 10;
`endif
  localparam int LAT32 = 34;
  localparam int LAT8  = 10;

  logic clk = 1'b0;
  logic rst;

  logic        flush32, in_valid32, in_ready32, sign32, out_valid32, out_ready32, dbz32, busy32;
  logic [31:0] a32, b32, q32, r32;
  logic        flush8, in_valid8, in_ready8, sign8, out_valid8, out_ready8, dbz8, busy8;
  logic [7:0]  a8, b8, q8, r8;

  int checks   = 0;
  int failures = 0;
  int nvld;

  always #5 clk = ~clk;

  div_radix2_param #(.WIDTH(32)) dut32 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush32),
    .in_valid   (in_valid32),
    .in_ready   (in_ready32),
    .sign       (sign32),
    .a          (a32),
    .b          (b32),
    .out_valid  (out_valid32),
    .out_ready  (out_ready32),
    .quotient   (q32),
    .remainder  (r32),
    .div_by_zero(dbz32),
    .busy       (busy32)
  );

  div_radix2_param #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush8),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .sign       (sign8),
    .a          (a8),
    .b          (b8),
    .out_valid  (out_valid8),
    .out_ready  (out_ready8),
    .quotient   (q8),
    .remainder  (r8),
    .div_by_zero(dbz8),
    .busy       (busy8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One 32-bit operation: accept, scramble operands, wait, optionally hold, consume.
  task automatic run32(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                       input int elat, input int hold, input string tag);
    int lat;
    chk({tag, "_in_ready"}, in_ready32, 1);
    a32 = ta; b32 = tbv; sign32 = ts; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    a32 = ~ta; b32 = tbv + 32'd5; sign32 = ~ts;
    lat = 1;
    while (out_valid32 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    for (int i = 0; i < hold; i++) begin
      in_valid32 = 1'b1;
      a32 = 32'd1 + i; b32 = 32'd1;
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, out_valid32, 1);
      chk({tag, "_hold_rdy"}, in_ready32, 0);
      chk({tag, "_hold_q"}, q32, eq);
    end
    in_valid32 = 1'b0;
    chk({tag, "_q"}, q32, eq);
    chk({tag, "_r"}, r32, er);
    chk({tag, "_dbz"}, dbz32, edbz);
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    chk({tag, "_vld_drop"}, out_valid32, 0);
    chk({tag, "_idle"}, busy32, 0);
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                      input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                      input int elat, input string tag);
    int lat;
    a8 = ta; b8 = tbv; sign8 = ts; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = ~ta; b8 = tbv + 8'd3;
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, q8, eq);
    chk({tag, "_r"}, r8, er);
    chk({tag, "_dbz"}, dbz8, edbz);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk({tag, "_vld_drop"}, out_valid8, 0);
  endtask

  initial begin
    rst = 1'b0;
    flush32 = 1'b0; in_valid32 = 1'b0; sign32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0;
    flush8  = 1'b0; in_valid8  = 1'b0; sign8  = 1'b0; out_ready8  = 1'b0; a8  = '0; b8  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid32, 0);
    chk("rst_q", q32, 0);
    chk("rst_r", r32, 0);
    chk("rst_dbz", dbz32, 0);
    chk("rst_busy", busy32, 0);
    chk("rst_w8_valid", out_valid8, 0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready32, 1);

    run32(32'd100,        32'd7,        1'b0, 32'd14,       32'd2,        1'b0, LAT32,  0, "udiv");
    run32(32'hFFFFFFF9,   32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT32,  0, "sdiv");
    run32(32'hFFFFFFF9,   32'd2,        1'b0, 32'h7FFFFFFC, 32'd1,        1'b0, LAT32,  0, "udiv_big");
    run32(32'h80000000,   32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, LAT32,  0, "ovf");
    run32(32'd5,          32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, FAST32, 0, "dbz");
    run32(32'hFFFFFFFD,   32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, FAST32, 0, "dbz_s");
    run32(32'd1000,       32'd10,       1'b0, 32'd100,      32'd0,        1'b0, LAT32, 10, "hold");
    run32(32'd9,          32'd3,        1'b0, 32'd3,        32'd0,        1'b0, LAT32,  0, "b2b");

    // Flush while the counter reads 15; an in_valid in the same cycle is dropped.
    a32 = 32'd1000; b32 = 32'd7; sign32 = 1'b0; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("flush_busy_before", busy32, 1);
    flush32 = 1'b1; in_valid32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
    @(posedge clk); #1;
    flush32 = 1'b0; in_valid32 = 1'b0;
    chk("flush_idle", busy32, 0);
    chk("flush_in_ready", in_ready32, 1);
    nvld = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid32 !== 1'b0 || busy32 !== 1'b0) nvld++;
    end
    chk("flush_no_valid", nvld, 0);

    run32(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0, LAT32, 0, "pre_rst");

    // Asynchronous reset in the middle of CALC.
    a32 = 32'd77; b32 = 32'd3; sign32 = 1'b0; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", busy32, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy32, 0);
    chk("arst_valid", out_valid32, 0);
    chk("arst_q", q32, 0);
    chk("arst_r", r32, 0);
    chk("arst_dbz", dbz32, 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    run32(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, LAT32, 0, "post_rst");

    run8(8'hFB, 8'd3,  1'b1, 8'hFF, 8'hFE, 1'b0, LAT8,  "w8_s");
    run8(8'hFB, 8'd3,  1'b0, 8'h53, 8'h02, 1'b0, LAT8,  "w8_u");
    run8(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, LAT8,  "w8_ovf");
    run8(8'd2,  8'd9,  1'b0, 8'h00, 8'h02, 1'b0, FAST8, "w8_small");
    run8(8'd7,  8'd0,  1'b1, 8'hFF, 8'h07, 1'b1, FAST8, "w8_dbz");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_radix2_param.md
Name: div_radix2_param

Overview:
- Parametrised, handshaked radix-2 restoring divider for the EX stage. It is the successor to the fixed 32-bit divider.
- Operand width is generic. Inputs and outputs use valid/ready handshakes, so the block can sit behind a stalling pipeline or a multi-cycle ALU arbiter.
- Adds explicit divide-by-zero handling and a registered sign-fix stage.
- Inputs are captured at accept, so operand forwarding changes after accept have no effect. Flush aborts the operation.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values are 8 to 64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- flush  in  1  synchronous abort; highest priority after rst
- in_valid  in  1  operands present
- in_ready  out  1  block can accept a new operation
- sign  in  1  1 = signed, 0 = unsigned
- a  in  WIDTH  dividend
- b  in  WIDTH  divisor
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- quotient  out  WIDTH  quotient
- remainder  out  WIDTH  remainder
- div_by_zero  out  1  b was 0; qualified by out_valid
- busy  out  1  state != IDLE; used for pipeline stall

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - out_valid=0, div_by_zero=0, quotient=0, remainder=0.
  - in_ready=1 once rst is released.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready&!flush:
    - latch sign, a[MSB] and b[MSB].
    - load the shift register with {0, |a|, 0-shift}.
    - load the negated divisor magnitude in WIDTH+1 bits.
    - counter=1, go to CALC.
- CALC:
  - One quotient bit per cycle: trial-subtract the WIDTH+1-bit divisor magnitude, restore if the carry is 0, shift left.
  - Exactly WIDTH cycles; counter runs 1..WIDTH.
  - At counter==WIDTH, write the final remainder and last quotient bit, then go to FIX.
- FIX:
  - Apply signs: the remainder takes the sign of the dividend; the quotient is negated when sign & (a_msb ^ b_msb).
  - Register quotient/remainder, go to DONE.
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero are held stable while out_valid & !out_ready.
  - On out_ready, go to IDLE; out_valid falls on that edge.
- Latency:
  - out_valid rises WIDTH+2 edges after the accepting edge.
  - WIDTH=32 gives 34 cycles.
  - Throughput is one operation per WIDTH+3 cycles minimum, since the result handshake takes 1 cycle.
- in_ready=0 in CALC, FIX and DONE. No new operation is accepted until the result is consumed.
- Divide-by-zero (b==0):
  - quotient = all ones, remainder = a (unmodified, either sign).
  - div_by_zero=1.
  - Same latency as a normal operation unless DIV_FAST_PATH_EN is defined.
- Signed overflow (a=MIN, b=-1, sign=1): quotient=MIN, remainder=0, div_by_zero=0. The |a| and WIDTH+1-bit divisor arithmetic produces this naturally.
- flush=1 in any state:
  - next state=IDLE, counter=0, out_valid=0.
  - An in_valid in the same cycle is ignored.
  - Output data registers may keep stale values.
- flush and out_ready in the same cycle in DONE: flush wins; the result is treated as discarded.
- busy = (state != IDLE).

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined: in IDLE at accept, the CALC/FIX states are skipped and the block goes directly to DONE, giving out_valid 1 edge after accept, when either condition holds:
  - b==0: div_by_zero result as above.
  - |a| < |b| and b!=0: quotient=0, remainder=a.
- Not defined: every operation takes WIDTH+2 cycles; results are identical.

Decomposition:
- Shared package div_pkg:
  - state enum (IDLE, CALC, FIX, DONE).
  - localparam helpers for CNT_W.
- One natural sub-module: div_sign_fix, a combinational conditional two's-complement negate of quotient/remainder. It is also reusable by the multiplier.
- The iteration datapath stays inline.

Test Plan:
- Unsigned, WIDTH=32: a=100, b=7, sign=0 -> after 34 cycles quotient=14, remainder=2, div_by_zero=0.
- Signed: a=-7 (0xFFFFFFF9), b=2, sign=1 -> quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF).
- Signed overflow and zero divisor:
  - a=0x80000000, b=0xFFFFFFFF, sign=1 -> quotient=0x80000000, remainder=0.
  - a=5, b=0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- Handshake:
  - Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0.
  - Assert out_ready -> IDLE next edge; a back-to-back accept is legal from the following cycle.
- Flush and reset mid-operation:
  - flush at counter=15 -> IDLE next edge, out_valid never rises.
  - rst=0 mid-CALC -> immediate IDLE, all outputs 0.
  - A new a=9, b=3 afterwards -> quotient=3, remainder=0.
- Parametrisation: WIDTH=8, a=0xFB (-5), b=3, sign=1 -> quotient=0xFF (-1), remainder=0xFE (-2), latency 10 cycles. With DIV_FAST_PATH_EN, a=2, b=9 -> out_valid 1 cycle after accept.
